unidad_control: RTL
===================

# unidad_control

Sequential control unit for the `microc` datapath. It consumes the datapath's `opcode[5:0]` and zero flag `z`, and produces `s_inc`, `s_inm`, `we3`, `op[2:0]` and a PC enable. It adds a boot cycle after reset, a registered zero flag for conditional jumps, a HALT state and a retired-instruction counter. It sits directly beside `microc` in the CPU top level and closes the opcode → control loop.

## Interface
- CNT_W, 16, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous reset, active-high
- opcode  in  6  current instruction opcode from the datapath
- z  in  1  combinational ALU zero output from the datapath
- s_inc  out  1  PC source: 1 = PC+1, 0 = jump target
- s_inm  out  1  register write source: 1 = immediate, 0 = ALU result
- we3  out  1  register file write enable
- op  out  3  ALU operation select
- pc_en  out  1  PC load enable (top level gates the PC register with it)
- halted  out  1  high while in HALT
- retired  out  CNT_W  count of executed instructions

## Operation
- Decode, fixed encoding:
  - 0xxxxx: ALU. op=opcode[4:2], s_inm=0, we3=1, s_inc=1.
  - 1000xx: LI. op=000, s_inm=1, we3=1, s_inc=1.
  - 1001xx: J. s_inc=0, we3=0.
  - 1010xx: JZ. s_inc=~z_flag, we3=0.
  - 1011xx: JNZ. s_inc=z_flag, we3=0.
  - 111111: HALT.
  - Other 11xxxx: NOP. we3=0, s_inc=1.
- FSM states:
  - BOOT: entered on reset. Lasts one cycle, then goes to RUN.
  - RUN: executes one instruction per cycle.
  - HALT: absorbing; left only by reset.
- RUN → HALT when opcode=111111 is decoded in RUN. The HALT instruction counts as retired.
- In BOOT and HALT: pc_en=0, we3=0, s_inc=1, s_inm=0, op=000, so no architectural state changes.
- In RUN: pc_en=1 and outputs follow the decode table. Outputs are combinational from state, opcode and z_flag.
- z_flag register:
  - Captures `z` on the clock edge that ends an ALU instruction in RUN.
  - Unchanged by LI, jumps, NOP and HALT.
  - JZ/JNZ read z_flag, never raw `z`.
- retired increments by 1 on every RUN cycle and wraps from all-ones to 0. It is frozen in BOOT and HALT.
- halted=1 exactly when state=HALT.

## Timing
- Reset, synchronous: on a clk edge with reset=1, state=BOOT, z_flag=0, retired=0.
  - Outputs during BOOT: pc_en=0, we3=0, s_inc=1, s_inm=0, op=000, halted=0.
- First instruction executes in the second cycle after reset deasserts; the PC first advances at the end of that cycle.
- Decode latency is zero cycles (same cycle as opcode). z_flag latency is one cycle: an ALU instruction at cycle n affects a JZ/JNZ at cycle n+1.
- Reset asserted mid-instruction (any state) wins over every other update: no z_flag capture and no retired increment on that edge.
- Reset is the only exit from HALT.
- An opcode that changes while in BOOT/HALT has no effect.

## Test plan
- Reset held 2 cycles, then released → cycle 1: pc_en=0, we3=0, retired=0. Cycle 2 with opcode=100000 (LI): pc_en=1, we3=1, s_inm=1, op=000. retired=1 after that edge.
- ALU opcode 000100 with z=1 → op=001, we3=1, s_inm=0. z_flag=1 afterwards. Next opcode 101000 (JZ) → s_inc=0. Same sequence with z=0 → s_inc=1.
- LI with z=1 after an ALU with z=0 → z_flag remains 0. A following JNZ (101100) gives s_inc=0.
- J (100100) → s_inc=0, we3=0, pc_en=1. NOP 110000 → s_inc=1, we3=0, retired increments.
- HALT 111111 → next cycle halted=1, pc_en=0, we3=0. retired stays constant over 5 cycles with varied opcodes. Reset returns to BOOT, with halted=0 and retired=0.
- Force retired to 16'hFFFF via 65535 RUN cycles, then one more RUN cycle → retired=0. Reset asserted during an ALU cycle with z=1 → z_flag=0.

Source files
------------

// File: rtl/unidad_control_if.sv
// unidad_control_if: control-unit <-> datapath signal bundle.
//   opcode  : current instruction opcode from the datapath
//   z       : combinational ALU zero output from the datapath
//   s_inc   : PC source (1 = PC+1, 0 = jump target)
//   s_inm   : register write source (1 = immediate, 0 = ALU result)
//   we3     : register file write enable
//   op      : ALU operation select
//   pc_en   : PC load enable
//   halted  : high while the control unit sits in HALT
//   retired : count of executed instructions (wraps)
// Modports: master = control unit side, slave = datapath / top-level side.
interface unidad_control_if #(
    parameter int unsigned CNT_W = 16
) ();
    localparam int unsigned OPC_W = 6;
    localparam int unsigned OP_W  = 3;

    logic [OPC_W-1:0] opcode;
    logic             z;
    logic             s_inc;
    logic             s_inm;
    logic             we3;
    logic [OP_W-1:0]  op;
    logic             pc_en;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode,
        input  z,
        output s_inc,
        output s_inm,
        output we3,
        output op,
        output pc_en,
        output halted,
        output retired
    );

    modport slave (
        output opcode,
        output z,
        input  s_inc,
        input  s_inm,
        input  we3,
        input  op,
        input  pc_en,
        input  halted,
        input  retired
    );
endinterface

// File: rtl/unidad_control.sv
// unidad_control: sequential control unit for the microc datapath.
// Decodes the opcode into datapath controls, inserts one boot cycle after
// reset, keeps a registered zero flag for conditional jumps, stops in an
// absorbing HALT state and counts retired instructions.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous reset, active-high
//   bus   : unidad_control_if.master (opcode/z in, controls/status out)
// Control outputs are combinational from state, opcode and the zero flag.
module unidad_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    unidad_control_if.master  bus
);

    localparam int unsigned OP_W = 3;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic             z_flag_q;
    logic [CNT_W-1:0] retired_q;

    logic             is_alu;
    logic             s_inc;
    logic             s_inm;
    logic             we3;
    logic [OP_W-1:0]  op;
    logic             pc_en;
    logic             halted;

    // ALU class is the whole lower half of the opcode space.
    assign is_alu = ~bus.opcode[5];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_n;
        end
    end

    // Zero flag and retired counter only advance on RUN cycles; reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            z_flag_q  <= 1'b0;
            retired_q <= '0;
        end else if (state_q == ST_RUN) begin
            retired_q <= retired_q + CNT_W'(1);
            if (is_alu) begin
                z_flag_q <= bus.z;
            end
        end
    end

    // Next-state and decode; BOOT/HALT leave the safe defaults in place.
    always_comb begin
        state_n = state_q;
        pc_en   = 1'b0;
        we3     = 1'b0;
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        op      = '0;
        halted  = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_n = ST_RUN;
            end
            ST_RUN: begin
                pc_en = 1'b1;
                casez (bus.opcode)
                    6'b0?????: begin
                        op  = bus.opcode[4:2];
                        we3 = 1'b1;
                    end
                    6'b1000??: begin
                        s_inm = 1'b1;
                        we3   = 1'b1;
                    end
                    6'b1001??: begin
                        s_inc = 1'b0;
                    end
                    // Conditional jumps look only at the registered flag.
                    6'b1010??: begin
                        s_inc = ~z_flag_q;
                    end
                    6'b1011??: begin
                        s_inc = z_flag_q;
                    end
                    6'b111111: begin
                        state_n = ST_HALT;
                    end
                    default: begin
                        // Remaining 11xxxx opcodes are NOPs.
                    end
                endcase
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_n = ST_BOOT;
            end
        endcase
    end

    assign bus.s_inc   = s_inc;
    assign bus.s_inm   = s_inm;
    assign bus.we3     = we3;
    assign bus.op      = op;
    assign bus.pc_en   = pc_en;
    assign bus.halted  = halted;
    assign bus.retired = retired_q;

endmodule
